lcd1602_refresh_ctrl: RTL and testbench

- Downstream consumer of the BCD-to-ASCII stage in the frequency meter.
- Powers up and initialises an HD44780-compatible 16x2 LCD in 8-bit mode, then continuously refreshes line 1 with NUM_CHARS characters.
- Each character is fetched by driving char_idx; the digit mux and ASCII stage return a 9-bit word {RS, data}.
- Generates all LCD bus timing (RS, RW, EN, D[7:0]) from the system clock.

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_write_engine.sv | 85 ++++++++
 rtl/lcd1602_refresh_ctrl.sv | 151 +++++++++++++++
 tb/tb_lcd1602_refresh_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD1602 refresh controller.
// Holds the HD44780 command bytes, the controller and write-engine state
// enums, the {RS, code} word type and a lookup for the init command sequence.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNCSET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_DISPON  = 8'h0C;  // display on, cursor off
   localparam logic [7:0] CMD_ENTRY   = 8'h06;  // auto-increment, no shift
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_LINE1   = 8'h80;  // DDRAM address 0x00

   localparam int unsigned NUM_INIT_CMDS = 4;

   typedef enum logic [2:0] {
      S_PWRUP,
      S_INIT,
      S_CLRWAIT,
      S_HOME,
      S_FETCH,
      S_WRITE
   } state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_PULSE,
      PH_HOLD
   } phase_e;

   typedef struct packed {
      logic       rs;
      logic [7:0] code;
   } lcd_word_t;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNCSET;
         2'd1:    return CMD_DISPON;
         2'd2:    return CMD_ENTRY;
         default: return CMD_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd_write_engine.sv
// Three-phase EN strobe generator for one LCD bus write.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       request a write; honoured only while idle
//   word        {rs, code} latched on the accepted start cycle
//   busy        high from the cycle after start until the final HOLD cycle
//   done        one-cycle pulse on the final HOLD cycle
//   lcd_rs, lcd_data  latched word, held until the next accepted start
//   lcd_en      high for the PULSE phase only
module lcd_write_engine
   import lcd_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  lcd_word_t  word,
   output logic       busy,
   output logic       done,
   output logic       lcd_rs,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

   phase_e           phase_q, phase_d;
   logic [TickW-1:0] cnt_q, cnt_d;
   lcd_word_t        word_q, word_d;

   logic phase_end;
   assign phase_end = (cnt_q == TickLast);

   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      done    = 1'b0;
      case (phase_q)
         PH_IDLE: begin
            if (start) begin
               word_d  = word;
               cnt_d   = '0;
               phase_d = PH_SETUP;
            end
         end
         PH_SETUP: begin
            cnt_d = phase_end ? '0 : cnt_q + TickW'(1);
            if (phase_end) phase_d = PH_PULSE;
         end
         PH_PULSE: begin
            cnt_d = phase_end ? '0 : cnt_q + TickW'(1);
            if (phase_end) phase_d = PH_HOLD;
         end
         PH_HOLD: begin
            cnt_d = phase_end ? '0 : cnt_q + TickW'(1);
            if (phase_end) begin
               done    = 1'b1;
               phase_d = PH_IDLE;
            end
         end
         default: phase_d = PH_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end

   assign busy     = (phase_q != PH_IDLE);
   assign lcd_en   = (phase_q == PH_PULSE);
   assign lcd_rs   = word_q.rs;
   assign lcd_data = word_q.code;

endmodule

// File: rtl/lcd1602_refresh_ctrl.sv
// LCD1602 power-up, initialisation and continuous line-1 refresh controller.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   char_in      {RS, code} from the ASCII stage for the character at char_idx
//   char_idx     index of the character being fetched, stable for a whole byte
//   lcd_rs, lcd_rw, lcd_en, lcd_data   HD44780 bus (write-only, rw tied 0)
//   init_done    sticky flag once the init sequence and clear wait have finished
//   frame_done   one-cycle pulse after the last character of each frame
module lcd1602_refresh_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 50,
   parameter int unsigned POWERUP_CYC = 2000000,
   parameter int unsigned CLEAR_CYC   = 100000,
   parameter int unsigned NUM_CHARS   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] char_in,
   output logic [3:0] char_idx,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data,
   output logic       init_done,
   output logic       frame_done
);

   localparam int unsigned MaxWait = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
   localparam int unsigned WaitW   = $clog2(MaxWait + 1);
   localparam logic [3:0]  LastIdx = 4'(NUM_CHARS - 1);
   localparam logic [1:0]  LastCmd = 2'(NUM_INIT_CMDS - 1);

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [3:0]       idx_q, idx_d;
   logic             init_q, init_d;
   logic             frame_q, frame_d;

   logic      wr_start, wr_busy, wr_done;
   lcd_word_t wr_word;

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      cmd_d    = cmd_q;
      idx_d    = idx_q;
      init_d   = init_q;
      frame_d  = 1'b0;
      wr_start = 1'b0;
      wr_word  = '0;
      case (state_q)
         S_PWRUP: begin
            if (wait_q == WaitW'(POWERUP_CYC - 1)) begin
               wait_d  = '0;
               state_d = S_INIT;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         S_INIT: begin
            // The engine is only idle on the first cycle here and on the cycle
            // after each done, so this issues exactly one start per command.
            wr_start     = !wr_busy;
            wr_word.rs   = 1'b0;
            wr_word.code = init_cmd(cmd_q);
            if (wr_done) begin
               if (cmd_q == LastCmd) begin
                  cmd_d   = '0;
                  state_d = S_CLRWAIT;
               end else begin
                  cmd_d = cmd_q + 2'd1;
               end
            end
         end
         S_CLRWAIT: begin
            if (wait_q == WaitW'(CLEAR_CYC - 1)) begin
               wait_d  = '0;
               init_d  = 1'b1;
               state_d = S_HOME;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         S_HOME: begin
            wr_start     = !wr_busy;
            wr_word.rs   = 1'b0;
            wr_word.code = CMD_LINE1;
            idx_d        = '0;
            if (wr_done) state_d = S_FETCH;
         end
         S_FETCH: begin
            // Settling cycle for the upstream mux driven from char_idx.
            state_d = S_WRITE;
         end
         S_WRITE: begin
            wr_start = !wr_busy;
            wr_word  = lcd_word_t'(char_in);
            if (wr_done) begin
               if (idx_q == LastIdx) begin
                  frame_d = 1'b1;
                  state_d = S_HOME;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_PWRUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_PWRUP;
         wait_q  <= '0;
         cmd_q   <= '0;
         idx_q   <= '0;
         init_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         init_q  <= init_d;
         frame_q <= frame_d;
      end
   end

   lcd_write_engine #(
      .TICK_DIV (TICK_DIV)
   ) u_engine (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (wr_start),
      .word     (wr_word),
      .busy     (wr_busy),
      .done     (wr_done),
      .lcd_rs   (lcd_rs),
      .lcd_en   (lcd_en),
      .lcd_data (lcd_data)
   );

   assign lcd_rw     = 1'b0;
   assign char_idx   = idx_q;
   assign init_done  = init_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_lcd1602_refresh_ctrl.sv
// Bench for lcd1602_refresh_ctrl: a byte-schedule model derived from the
// sequencing rules predicts every bus output per cycle; char_in is driven from
// per-frame tables on fetch/sample cycles and with random junk otherwise.
module tb_lcd1602_refresh_ctrl;

   localparam int T  = 2;
   localparam int P  = 10;
   localparam int C  = 8;
   localparam int N  = 4;
   localparam int B  = 3 * T;                 // cycles per byte inside the engine
   localparam int F  = (B + 1) + N * (B + 2); // frame: home byte + N fetch/write slots
   localparam int H0 = P + 4 * (B + 1) + C;   // first HOME start cycle
   localparam int NF = 5;
   localparam int RST_C = H0 + 3 * F + 3 * (B + 2) + T + 1; // PULSE of char 2, frame 3

   logic       clk;
   logic       rst_n;
   logic [8:0] char_in;
   logic [3:0] char_idx;
   logic       lcd_rs, lcd_rw, lcd_en, init_done, frame_done;
   logic [7:0] lcd_data;

   lcd1602_refresh_ctrl #(
      .TICK_DIV    (T),
      .POWERUP_CYC (P),
      .CLEAR_CYC   (C),
      .NUM_CHARS   (N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .char_in    (char_in),
      .char_idx   (char_idx),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_en     (lcd_en),
      .lcd_data   (lcd_data),
      .init_done  (init_done),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;
   bit running = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   logic [8:0] tbl [8][N];

   typedef struct {
      int         s;
      logic       rs;
      logic [7:0] data;
   } byte_t;
   byte_t sched[$];

   typedef struct {
      logic       en;
      logic       rs;
      logic [7:0] data;
      logic [3:0] idx;
      logic       init;
      logic       frame;
   } exp_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
      end
   endtask

   task automatic build_tables();
      logic [8:0] w;
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < N; i++) begin
            if (f == 0)      w = 9'h130 + 9'(i);
            else if (f == 1) w = (i == 2) ? 9'h146 : 9'h120;
            else             w = 9'($urandom);
            tbl[f][i] = w;
         end
      end
   endtask

   task automatic build_sched();
      logic [7:0] cmds [4];
      byte_t      b;
      int         h;
      cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
      sched.delete();
      for (int k = 0; k < 4; k++) begin
         b.s = P + k * (B + 1); b.rs = 1'b0; b.data = cmds[k];
         sched.push_back(b);
      end
      for (int f = 0; f < NF; f++) begin
         h = H0 + f * F;
         b.s = h; b.rs = 1'b0; b.data = 8'h80;
         sched.push_back(b);
         for (int i = 0; i < N; i++) begin
            b.s = h + (i + 1) * (B + 2); b.rs = tbl[f][i][8]; b.data = tbl[f][i][7:0];
            sched.push_back(b);
         end
      end
   endtask

   function automatic exp_t model(input int c);
      exp_t e;
      int   r, k, rr;
      e = '{default: '0};
      foreach (sched[j]) begin
         if (sched[j].s < c) begin
            e.rs   = sched[j].rs;
            e.data = sched[j].data;
         end
         if (c >= sched[j].s + T + 1 && c <= sched[j].s + 2 * T) e.en = 1'b1;
      end
      e.init = (c >= H0);
      if (c > H0) begin
         r  = c - H0;
         k  = r / F;
         rr = r % F;
         if (rr == 0) e.idx = 4'(N - 1);
         else if (rr <= B + 1) e.idx = 4'd0;
         else e.idx = 4'(((rr - (B + 1)) / (B + 2) > N - 1) ? N - 1 : (rr - (B + 1)) / (B + 2));
         e.frame = (rr == 0) && (k > 0);
      end
      return e;
   endfunction

   // Upstream emulation: valid only on fetch and sample cycles, junk elsewhere.
   always @(negedge clk) begin
      int r, k, rr;
      logic [8:0] w;
      w = 9'($urandom);
      if (running && rst_n && cyc >= H0) begin
         r  = cyc - H0;
         k  = r / F;
         rr = r % F;
         if (rr >= B + 1 && ((rr - (B + 1)) % (B + 2)) <= 1 && k < 8) begin
            w = tbl[k][char_idx & 4'(N - 1)];
         end
      end
      char_in = w;
   end

   always @(negedge clk) begin
      exp_t e;
      if (running && rst_n) begin
         e = model(cyc);
         check("lcd_en", 32'(lcd_en), 32'(e.en));
         check("lcd_rs", 32'(lcd_rs), 32'(e.rs));
         check("lcd_data", 32'(lcd_data), 32'(e.data));
         check("char_idx", 32'(char_idx), 32'(e.idx));
         check("init_done", 32'(init_done), 32'(e.init));
         check("frame_done", 32'(frame_done), 32'(e.frame));
         check("lcd_rw", 32'(lcd_rw), 32'd0);
         // Hand-derived anchors for the model itself.
         if (cyc == 9)   check("pin_pwrup_en", 32'(lcd_en), 32'd0);
         if (cyc == 13)  check("pin_first_cmd", {23'd0, lcd_en, lcd_data}, {23'd0, 1'b1, 8'h38});
         if (cyc == 15)  check("pin_first_hold", 32'(lcd_en), 32'd0);
         if (cyc == 45)  check("pin_init_lo", 32'(init_done), 32'd0);
         if (cyc == 46)  check("pin_init_hi", 32'(init_done), 32'd1);
         if (cyc == 50)  check("pin_home", {22'd0, lcd_en, lcd_rs, lcd_data},
                                {22'd0, 1'b1, 1'b0, 8'h80});
         if (cyc == 57)  check("pin_char0", {22'd0, lcd_en, lcd_rs, lcd_data},
                                {22'd0, 1'b1, 1'b1, 8'h30});
         if (cyc == 85)  check("pin_frame", 32'(frame_done), 32'd1);
         if (cyc == 112) check("pin_f_char", {22'd0, lcd_en, lcd_rs, lcd_data},
                                {22'd0, 1'b1, 1'b1, 8'h46});
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {18'd0, char_idx, lcd_rs, lcd_rw, lcd_en, lcd_data, init_done,
                             frame_done}, 32'd0);
   endtask

   initial begin
      int budget;
      rst_n = 1'b0;
      build_tables();
      build_sched();
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");

      @(posedge clk);
      #2 rst_n = 1'b1;
      running = 1'b1;

      budget = 1000;
      while (cyc != RST_C && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check("reach_reset_point", 32'(cyc), 32'(RST_C));
      #1 check("en_before_reset", 32'(lcd_en), 32'd1);
      running = 1'b0;
      rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      repeat (3) @(posedge clk);
      #1 check_all_zero("held_reset");

      build_tables();
      build_sched();
      @(posedge clk);
      #2 rst_n = 1'b1;
      running = 1'b1;
      repeat (H0 + 2 * F + 5) @(negedge clk);
      running = 1'b0;
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
